resultado_uart_tx: RTL
======================

Name: resultado_uart_tx

Overview:
- Transmit-side companion to the processor's 14-bit `resultado` output.
- Captures each result the core flags as valid and buffers it in a small FIFO.
- Serializes each result off-chip as two 8N1 UART frames, so a host can log program results instead of probing the bus in simulation.
- Sits beside `main`: reads its result bus and drives a single serial pin.

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per UART bit. Legal range ≥ 2.
- FIFO_DEPTH, default 4: number of 14-bit result entries. Power of 2, ≥ 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- resultado  input  14  result word from the processor.
- res_valid  input  1  capture strobe; `resultado` is sampled on any rising edge where this is high.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.
- overflow  output  1  sticky; set when a valid result is dropped.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: one clock, synchronous, active-low. While rst_n is sampled low:
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - FIFO pointers are cleared, the FSM goes to IDLE, and the bit counters clear.
  - Reset mid-frame aborts the frame: tx is 1 from the next edge and buffered results are discarded.
- Encoding: each result produces two bytes, sent in this order:
  - byte0 = {1'b1, resultado[13:7]}
  - byte1 = {1'b0, resultado[6:0]}
  - Bit 7 marks the high half, so the host can resynchronise.
- Frame format: 8N1, LSB first. Start bit 0, data bits d0..d7, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP. A half-select bit `hi_lo` chooses byte0 or byte1.
  - IDLE: if the FIFO is non-empty, pop the head into a 14-bit shift holding register, set hi_lo=byte0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = current byte[bit index] for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte0 was just sent: select byte1 and go to START (no idle gap).
    - If byte1 was just sent: go to IDLE, or pop the next entry directly and go to START if the FIFO is non-empty (back-to-back).
- Latency: with an empty FIFO in IDLE, res_valid is sampled at edge E, the FIFO writes at E, the pop happens at E+1, and tx goes low from E+2. Total per result = 20·CLKS_PER_BIT cycles.
- FIFO:
  - Push on res_valid when not full.
  - Pop only from IDLE or the STOP→START handoff of byte1.
  - Simultaneous push and pop when full: both happen, fifo_count unchanged, no overflow.
  - Push when full without a same-cycle pop: word dropped, overflow←1 and held until reset.
  - Pointers wrap modulo FIFO_DEPTH.
- busy = (fifo_count≠0) | (state≠IDLE). It is registered-consistent with the state, so no glitch between back-to-back results.
- Back-to-back res_valid on consecutive cycles is legal; each cycle is a separate result.
- `resultado` is not required to be stable outside sampled edges.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with res_valid=0 for 50 cycles → tx=1, busy=0, overflow=0, fifo_count=0 throughout.
- Single result: CLKS_PER_BIT=4, pulse res_valid with resultado=14'h2A5B.
  - tx low exactly 2 edges later.
  - Decoded bytes are 0xD4 then 0x5B.
  - busy drops 80 cycles after tx first falls.
- Extremes: send 14'h0000 then 14'h3FFF back-to-back → decoded bytes 0x80, 0x00, 0xFF, 0x7F; stop bit high; no idle cycles between frames.
- Overflow: FIFO_DEPTH=4, pulse res_valid on 6 consecutive cycles with values 1..6.
  - 1 is popped immediately, 2–5 are buffered, 6 is dropped.
  - overflow=1 from the 6th edge.
  - Output stream = results 1,2,3,4,5.
- Full + simultaneous: arrange FIFO full, then assert res_valid on the exact cycle of the byte1 STOP→pop → word accepted, fifo_count stays 4, overflow stays 0.
- Reset mid-operation: assert rst_n=0 during the DATA state of byte0 with 2 entries queued → tx=1 from the next edge, fifo_count=0, busy=0, no further frames after release.

Source files
------------

// File: rtl/resultado_uart_tx_if.sv
// Result bus from the processor core: the 14-bit result word and its capture strobe.
interface resultado_uart_tx_if;
  logic [13:0] resultado;
  logic        res_valid;

  modport master (output resultado, output res_valid);
  modport slave  (input  resultado, input  res_valid);
endinterface

// File: rtl/resultado_uart_tx.sv
// Buffers processor results in a small FIFO and sends each one as two 8N1 UART bytes:
// {1, res[13:7]} then {0, res[6:0]}, so the host can find the high half.
module resultado_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  resultado_uart_tx_if.slave          res,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic logic [7:0] frame_byte(input logic [13:0] word, input logic hi);
    logic [7:0] b;
    if (hi) begin
      b = {1'b1, word[13:7]};
    end else begin
      b = {1'b0, word[6:0]};
    end
    return b;
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic [13:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic            overflow_r;
  logic            busy_r;
  logic            tx_r;
  logic [CW-1:0]   clk_cnt_r;
  logic [2:0]      bit_idx_r;
  logic            hi_lo_r;
  logic [13:0]     hold_r;

  logic            bit_done_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic            pop_s;
  logic            push_s;
  logic            drop_s;
  logic            tx_s;
  logic [7:0]      cur_byte_s;

  assign bit_done_s   = (clk_cnt_r == LAST_CLK);
  assign fifo_empty_s = (count_r == {CNTW{1'b0}});
  assign fifo_full_s  = (count_r == FULL_CNT);
  assign cur_byte_s   = frame_byte(hold_r, hi_lo_r);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; STOP chains straight into START for byte1 and for queued results
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) state_s = START;
        else               state_s = IDLE;
      end
      START: begin
        if (bit_done_s) state_s = DATA;
        else            state_s = START;
      end
      DATA: begin
        if (bit_done_s && (bit_idx_r == 3'd7)) state_s = STOP;
        else                                   state_s = DATA;
      end
      STOP: begin
        if (bit_done_s) begin
          if (hi_lo_r || !fifo_empty_s) state_s = START;
          else                          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Per-state outputs: serial level, FIFO pop, push/drop decision
  always_comb begin
    tx_s  = 1'b1;
    pop_s = 1'b0;
    case (state_r)
      IDLE: begin
        tx_s  = 1'b1;
        pop_s = !fifo_empty_s;
      end
      START: begin
        tx_s  = 1'b0;
        pop_s = 1'b0;
      end
      DATA: begin
        tx_s  = cur_byte_s[bit_idx_r];
        pop_s = 1'b0;
      end
      STOP: begin
        tx_s  = 1'b1;
        pop_s = bit_done_s && !hi_lo_r && !fifo_empty_s;
      end
      default: begin
        tx_s  = 1'b1;
        pop_s = 1'b0;
      end
    endcase
    // A full FIFO still accepts a word on the cycle it pops
    push_s = res.res_valid && (!fifo_full_s || pop_s);
    drop_s = res.res_valid && fifo_full_s && !pop_s;
  end

  // Bit timing, byte select and the holding register for the word in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt_r <= {CW{1'b0}};
      bit_idx_r <= 3'd0;
      hi_lo_r   <= 1'b0;
      hold_r    <= 14'd0;
    end else begin
      if ((state_r == IDLE) || bit_done_s) clk_cnt_r <= {CW{1'b0}};
      else                                 clk_cnt_r <= clk_cnt_r + CW'(1'b1);

      if (state_r != DATA) bit_idx_r <= 3'd0;
      else if (bit_done_s) bit_idx_r <= bit_idx_r + 3'd1;
      else                 bit_idx_r <= bit_idx_r;

      if (pop_s)                                  hi_lo_r <= 1'b1;
      else if ((state_r == STOP) && bit_done_s)   hi_lo_r <= 1'b0;
      else                                        hi_lo_r <= hi_lo_r;

      if (pop_s) hold_r <= mem_r[rd_ptr_r];
      else       hold_r <= hold_r;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= res.resultado;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CNTW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1'b1);
        2'b01:   count_r <= count_r - CNTW'(1'b1);
        default: count_r <= count_r;
      endcase
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // Registered line and busy; both lag the state by one cycle so they stay aligned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= tx_s;
      busy_r <= !fifo_empty_s || (state_r != IDLE);
    end
  end

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign fifo_count = count_r;

endmodule
